// File: rtl/divider_array_reconstruct_seq.sv
// Rebuilds a dividend as q*d + r with an 8-step shift-add multiplier and reports the signed error.
// Optional error statistics are enabled by defining DIVIDER_RECON_ERR_STATS_EN.
module divider_array_reconstruct_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] n,
  input  logic [7:0]  d,
  input  logic [7:0]  q,
  input  logic [7:0]  r,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DIVIDER_RECON_ERR_STATS_EN
  input  logic        stats_clr,
  output logic [39:0] sq_err_sum,
  output logic [15:0] sample_cnt,
`endif
  output logic [15:0] n_rec,
  output logic [16:0] err
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] n_reg_q, n_reg_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  quot_q, quot_d;
  logic [2:0]  k_q, k_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      n_reg_q <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_reg_q <= n_reg_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_reg_d = n_reg_q;
    div_d   = div_q;
    quot_d  = quot_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          n_reg_d = n;
          div_d   = d;
          quot_d  = q;
          acc_d   = {8'b0, r};
          k_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        // Fixed 8-cycle latency: every quotient bit is visited, even when zero.
        if (quot_q[k_q]) acc_d = acc_q + ({8'b0, div_q} << k_q);
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign n_rec     = acc_q;
  assign err       = {1'b0, acc_q} - {1'b0, n_reg_q};

`ifdef DIVIDER_RECON_ERR_STATS_EN
  logic [39:0] sq_sum_q, sq_sum_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] err_abs;
  logic [33:0] err_sq;
  logic [40:0] sq_next;

  assign err_abs = err[16] ? (~err + 17'd1) : err;
  assign err_sq  = {17'b0, err_abs} * {17'b0, err_abs};
  assign sq_next = {1'b0, sq_sum_q} + {7'b0, err_sq};

  always_comb begin
    sq_sum_d = sq_sum_q;
    cnt_d    = cnt_q;
    if (stats_clr) begin
      sq_sum_d = '0;
      cnt_d    = '0;
    end else if (out_valid && out_ready) begin
      sq_sum_d = sq_next[40] ? '1 : sq_next[39:0];
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_sum_q <= '0;
      cnt_q    <= '0;
    end else begin
      sq_sum_q <= sq_sum_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sq_err_sum = sq_sum_q;
  assign sample_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_divider_array_reconstruct_seq.sv
// Directed self-checking bench for divider_array_reconstruct_seq.
// Define DIVIDER_RECON_ERR_STATS_EN to also exercise the error statistics.
module tb_divider_array_reconstruct_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_rec;
  logic [16:0] err;
`ifdef DIVIDER_RECON_ERR_STATS_EN
  logic        stats_clr;
  logic [39:0] sq_err_sum;
  logic [15:0] sample_cnt;
`endif

  int checks = 0;
  int errors = 0;

  divider_array_reconstruct_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DIVIDER_RECON_ERR_STATS_EN
    .stats_clr (stats_clr),
    .sq_err_sum(sq_err_sum),
    .sample_cnt(sample_cnt),
`endif
    .n_rec     (n_rec),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand set, scrambles the input ports during MUL, then waits for out_valid.
  task automatic start_and_wait(input logic [15:0] nv, input logic [7:0] dv, input logic [7:0] qv,
                                input logic [7:0] rv, input string tag);
    int cnt;
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    n = nv; d = dv; q = qv; r = rv;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 16'(~nv); d = 8'(~dv); q = 8'(~qv); r = 8'(~rv);
    check({tag, " in_ready in MUL"}, 64'(in_ready), 64'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick;
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'd8);
  endtask

  task automatic txn(input logic [15:0] nv, input logic [7:0] dv, input logic [7:0] qv,
                     input logic [7:0] rv, input logic [15:0] exp_rec, input logic [16:0] exp_err,
                     input string tag);
    out_ready = 1'b1;
    start_and_wait(nv, dv, qv, rv, tag);
    check({tag, " n_rec"}, 64'(n_rec), 64'(exp_rec));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    tick;
    check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; d = '0; q = '0; r = '0;
`ifdef DIVIDER_RECON_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset n_rec", 64'(n_rec), 64'd0);
    check("reset err", 64'(err), 64'd0);
`ifdef DIVIDER_RECON_ERR_STATS_EN
    check("reset sq_err_sum", 64'(sq_err_sum), 64'd0);
    check("reset sample_cnt", 64'(sample_cnt), 64'd0);
`endif
    tick;
    rst = 1'b0;
    tick;

    txn(16'd1000, 8'd7, 8'd142, 8'd6, 16'd1000, 17'd0, "exact");
    txn(16'd1000, 8'd7, 8'd143, 8'd0, 16'd1001, 17'd1, "approx_plus1");
    txn(16'd1000, 8'd7, 8'd142, 8'd3, 16'd997, 17'h1FFFD, "approx_minus3");
    txn(16'd0, 8'd255, 8'd255, 8'd255, 16'd65280, 17'h0FF00, "max");
    txn(16'd255, 8'd0, 8'd255, 8'd255, 16'd255, 17'd0, "d_zero");
    txn(16'd40, 8'd99, 8'd0, 8'd40, 16'd40, 17'd0, "q_zero");

    // Backpressure: outputs hold in DONE and in_valid pulses are ignored.
    out_ready = 1'b0;
    start_and_wait(16'd510, 8'd10, 8'd50, 8'd7, "bp");
    for (int i = 0; i < 5; i++) begin
      n = 16'(i * 77); d = 8'd3; q = 8'd9; r = 8'd1;
      in_valid = i[0];
      tick;
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp in_ready low", 64'(in_ready), 64'd0);
      check("bp n_rec stable", 64'(n_rec), 64'd507);
      check("bp err stable", 64'(err), 64'h1FFFD);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp released out_valid", 64'(out_valid), 64'd0);
    check("bp released in_ready", 64'(in_ready), 64'd1);
    tick;
    check("bp single handshake", 64'(out_valid), 64'd0);

    // Reset three cycles after accept aborts the transaction immediately.
    out_ready = 1'b1;
    n = 16'd300; d = 8'd3; q = 8'd100; r = 8'd5;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort n_rec", 64'(n_rec), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    txn(16'd300, 8'd3, 8'd100, 8'd5, 16'd305, 17'd5, "after_abort");

`ifdef DIVIDER_RECON_ERR_STATS_EN
    stats_clr = 1'b1;
    tick;
    stats_clr = 1'b0;
    txn(16'd1000, 8'd7, 8'd143, 8'd0, 16'd1001, 17'd1, "stats_plus1");
    txn(16'd1000, 8'd7, 8'd142, 8'd3, 16'd997, 17'h1FFFD, "stats_minus3");
    check("stats sq_err_sum", 64'(sq_err_sum), 64'd10);
    check("stats sample_cnt", 64'(sample_cnt), 64'd2);
    stats_clr = 1'b1;
    tick;
    stats_clr = 1'b0;
    check("stats clr sq_err_sum", 64'(sq_err_sum), 64'd0);
    check("stats clr sample_cnt", 64'(sample_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
